// File: rtl/video_in_pio_pkg.sv
// ---------------------------------------------------------------------------
// video_in_pio_pkg
// Shared constants for the video-in status PIO:
//   - Avalon register addresses
//   - edge-type encodings for the EDGE_TYPE parameter
//   - debounce counter width
// ---------------------------------------------------------------------------
package video_in_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_RSVD     = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    localparam int DEBOUNCE_CNT_W = 16;

endpackage

// File: rtl/video_in_status_debounce.sv
// ---------------------------------------------------------------------------
// video_in_status_debounce
// One status bit: a 2-flop synchroniser followed by a stability filter.
// The filtered output only follows the synchronised input after that input
// has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any shorter
// excursion restarts the count.
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   in_i       asynchronous status input
//   filtered_o debounced level
// ---------------------------------------------------------------------------
module video_in_status_debounce
    import video_in_pio_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter logic RESET_VALUE     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic filtered_o
);

    localparam logic [DEBOUNCE_CNT_W-1:0] CNT_LAST = DEBOUNCE_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                      sync1_q, sync_q;
    logic                      filt_q, filt_d;
    logic [DEBOUNCE_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (sync_q == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            // Input has now been different for DEBOUNCE_CYCLES samples.
            filt_d = sync_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + DEBOUNCE_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RESET_VALUE;
            sync_q  <= RESET_VALUE;
            filt_q  <= RESET_VALUE;
            cnt_q   <= '0;
        end else begin
            sync1_q <= in_i;
            sync_q  <= sync1_q;
            filt_q  <= filt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign filtered_o = filt_q;

endmodule

// File: rtl/video_in_status_pio.sv
// ---------------------------------------------------------------------------
// video_in_status_pio
// Avalon-MM input PIO returning debounced status lines from the video path.
// Per-bit synchroniser/debounce, then edge capture with a maskable level irq.
// Register map: 0 filtered data (RO), 1 reserved (0), 2 irq_mask (RW),
//               3 edge_capture (write-1-to-clear).
// Build option: define VIDEO_IN_STATUS_PIO_BULK_CLEAR_EN to make any write
//   to address 3 clear every edge_capture bit regardless of writedata.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   address, chipselect,
//   write_n, writedata      Avalon slave write/select
//   readdata                zero-latency read data (combinational)
//   in_port                 asynchronous status inputs
//   irq                     level interrupt
// ---------------------------------------------------------------------------
module video_in_status_pio
    import video_in_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               DEBOUNCE_CYCLES = 4,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic             wr_en;
    // Writedata bits above WIDTH are dropped; keep them referenced.
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        video_in_status_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VALUE     (RESET_VALUE[i])
        ) u_db (
            .clk        (clk),
            .reset_n    (reset_n),
            .in_i       (in_port[i]),
            .filtered_o (filtered[i])
        );
    end

    assign wr_en = chipselect && !write_n;

    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALLING: evt = ~filtered & prev_q;
            EDGE_ANY:     evt = filtered ^ prev_q;
            default:      evt = filtered & ~prev_q;
        endcase
    end

    always_comb begin
        clr = '0;
        if (wr_en && address == ADDR_EDGE_CAP) begin
`ifdef VIDEO_IN_STATUS_PIO_BULK_CLEAR_EN
            clr = '1;
`else
            clr = writedata[WIDTH-1:0];
`endif
        end
    end

    // OR-ing the event after the clear lets a same-cycle event win.
    assign cap_d  = (cap_q & ~clr) | evt;
    assign mask_d = (wr_en && address == ADDR_IRQ_MASK) ? writedata[WIDTH-1:0] : mask_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= RESET_VALUE;
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            prev_q <= filtered;
            mask_q <= mask_d;
            cap_q  <= cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0] = filtered;
            ADDR_IRQ_MASK: readdata[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP: readdata[WIDTH-1:0] = cap_q;
            default:       readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_video_in_status_pio.sv
module tb_video_in_status_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  addr1, addr2;
    logic        cs1, cs2, wrn1, wrn2;
    logic [31:0] wd1, wd2, rd1, rd2;
    logic [3:0]  in1, in2;
    logic        irq1, irq2;
    logic [31:0] v;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Rising-edge capture instance
    video_in_status_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0), .RESET_VALUE(4'b0000)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(addr1), .chipselect(cs1), .write_n(wrn1),
        .writedata(wd1), .readdata(rd1), .in_port(in1), .irq(irq1));

    // Falling-edge capture instance
    video_in_status_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .RESET_VALUE(4'b0000)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(addr2), .chipselect(cs2), .write_n(wrn2),
        .writedata(wd2), .readdata(rd2), .in_port(in2), .irq(irq2));

    typedef struct {
        logic        do_wr;
        logic [1:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input int d, input logic [1:0] a, input logic [31:0] val);
        if (d == 1) begin cs1 = 1'b1; wrn1 = 1'b0; addr1 = a; wd1 = val; end
        else        begin cs2 = 1'b1; wrn2 = 1'b0; addr2 = a; wd2 = val; end
        tick(1);
        cs1 = 1'b0; wrn1 = 1'b1; cs2 = 1'b0; wrn2 = 1'b1;
    endtask

    task automatic rd(input int d, input logic [1:0] a, output logic [31:0] val);
        if (d == 1) addr1 = a; else addr2 = a;
        #1;
        val = (d == 1) ? rd1 : rd2;
    endtask

    initial begin
        reset_n = 1'b0;
        cs1 = 0; wrn1 = 1; addr1 = 0; wd1 = 0; in1 = 4'b0000;
        cs2 = 0; wrn2 = 1; addr2 = 0; wd2 = 0; in2 = 4'b0000;

        //           do_wr waddr wdata          raddr exp_rd        exp_irq
        tbl[0] = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0,        1'b0};
        tbl[2] = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0,        1'b0};
        tbl[3] = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h0,        1'b0};
        tbl[4] = '{1'b1, 2'd0, 32'hF,         2'd0, 32'h0,        1'b0};
        tbl[5] = '{1'b1, 2'd2, 32'hFFFF_FFF5, 2'd2, 32'h5,        1'b0};
        tbl[6] = '{1'b1, 2'd1, 32'hF,         2'd1, 32'h0,        1'b0};
        tbl[7] = '{1'b1, 2'd3, 32'hF,         2'd3, 32'h0,        1'b0};
        tbl[8] = '{1'b1, 2'd2, 32'h1,         2'd2, 32'h1,        1'b0};

        // Reset state while held in reset
        #2;
        for (int a = 0; a < 4; a++) begin
            rd(1, 2'(a), v);
            chk($sformatf("reset_rd%0d", a), v, 32'h0);
        end
        chk("reset_irq", {31'b0, irq1}, 32'h0);

        @(posedge clk); @(posedge clk); #1;
        reset_n = 1'b1;
        tick(20);
        rd(1, 2'd0, v); chk("idle_data", v, 32'h0);
        chk("idle_irq", {31'b0, irq1}, 32'h0);

        // Register access vectors
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].do_wr) wr(1, tbl[i].waddr, tbl[i].wdata);
            else              tick(1);
            rd(1, tbl[i].raddr, v);
            chk($sformatf("vec%0d_rd", i), v, tbl[i].exp_rd);
            chk($sformatf("vec%0d_irq", i), {31'b0, irq1}, {31'b0, tbl[i].exp_irq});
        end

        // Latency of a held rising edge on bit 0 (mask = 1)
        in1 = 4'b0001;
        tick(5);
        rd(1, 2'd0, v); chk("lat_data_k5", v, 32'h0);
        tick(1);
        rd(1, 2'd0, v); chk("lat_data_k6", v, 32'h1);
        rd(1, 2'd3, v); chk("lat_cap_k6", v, 32'h0);
        chk("lat_irq_k6", {31'b0, irq1}, 32'h0);
        tick(1);
        rd(1, 2'd3, v); chk("lat_cap_k7", v, 32'h1);
        chk("lat_irq_k7", {31'b0, irq1}, 32'h1);
        wr(1, 2'd3, 32'h1);
        rd(1, 2'd3, v); chk("w1c_cap", v, 32'h0);
        chk("w1c_irq", {31'b0, irq1}, 32'h0);

        // 3-cycle glitch on bit 1 is rejected
        in1 = 4'b0011;
        tick(3);
        in1 = 4'b0001;
        tick(10);
        rd(1, 2'd0, v); chk("glitch3_data", v, 32'h1);
        rd(1, 2'd3, v); chk("glitch3_cap", v, 32'h0);

        // 4-cycle pulse on bit 1 is accepted
        in1 = 4'b0011;
        tick(4);
        in1 = 4'b0001;
        tick(2);
        rd(1, 2'd0, v); chk("pulse4_data", v, 32'h3);
        tick(1);
        rd(1, 2'd3, v); chk("pulse4_cap", v, 32'h2);
        chk("pulse4_irq_masked", {31'b0, irq1}, 32'h0);
        tick(10);
        rd(1, 2'd0, v); chk("pulse4_data_back", v, 32'h1);
        rd(1, 2'd3, v); chk("pulse4_cap_sticky", v, 32'h2);
        wr(1, 2'd3, 32'hF);

        // Clear of bit 3 lands on the same edge as its capture: set wins
        in1 = 4'b1001;
        tick(6);
        wr(1, 2'd3, 32'h8);
        rd(1, 2'd3, v); chk("set_wins", v, 32'h8);
        wr(1, 2'd3, 32'h0);
        rd(1, 2'd3, v);
`ifdef VIDEO_IN_STATUS_PIO_BULK_CLEAR_EN
        chk("bulk_clear", v, 32'h0);
`else
        chk("w0_no_clear", v, 32'h8);
        wr(1, 2'd3, 32'h8);
        rd(1, 2'd3, v); chk("w1c_bit3", v, 32'h0);
`endif

        // Reset mid-debounce on bit 2
        wr(1, 2'd2, 32'hF);
        in1 = 4'b1101;
        tick(4);
        reset_n = 1'b0;
        rd(1, 2'd0, v); chk("midrst_data", v, 32'h0);
        rd(1, 2'd2, v); chk("midrst_mask", v, 32'h0);
        chk("midrst_irq", {31'b0, irq1}, 32'h0);
        tick(1);
        reset_n = 1'b1;
        tick(5);
        rd(1, 2'd0, v); chk("postrst_data_k5", v, 32'h0);
        tick(1);
        rd(1, 2'd0, v); chk("postrst_data_k6", v, 32'hD);
        tick(1);
        rd(1, 2'd3, v); chk("postrst_cap", v, 32'hD);
        chk("postrst_irq", {31'b0, irq1}, 32'h0);

        // Falling-edge instance: rise ignored, fall captured, late unmask
        in2 = 4'b0100;
        tick(12);
        rd(2, 2'd3, v); chk("fall_rise_ignored", v, 32'h0);
        in2 = 4'b0000;
        tick(6);
        rd(2, 2'd0, v); chk("fall_data", v, 32'h0);
        tick(1);
        rd(2, 2'd3, v); chk("fall_cap", v, 32'h4);
        chk("fall_irq_masked", {31'b0, irq2}, 32'h0);
        wr(2, 2'd2, 32'h4);
        chk("fall_irq_unmask", {31'b0, irq2}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
